f_pc_ctrl: RTL and testbench

F_PC_CTRL -- requirements
Module: f_pc_ctrl

---
 rtl/f_pc_ctrl.sv | 97 +++++++++
 tb/tb_f_pc_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/f_pc_ctrl.sv
// Fetch-stage PC controller: holds the fetch PC, latches the F/D pipeline register
// and resolves next-PC redirects from the D stage. One delay slot, no flush.
module f_pc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_signal_D,
  input  logic [2:0]  npc_op_D,
  input  logic [31:0] rs_fwd_D,
  input  logic [31:0] instr_F,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        exc_D
);

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_LO    = 32'h0000_3000;
  localparam logic [31:0] PC_HI    = 32'h0000_6FFC;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  localparam logic [2:0] NPC_SEQ    = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JR     = 3'b011;

  logic [31:0] pc_f_r;
  logic [31:0] instr_d_r;
  logic [31:0] pc_d_r;
  logic        exc_d_r;

  logic [31:0] pc_plus4_s;
  logic [31:0] imm_off_s;
  logic [31:0] branch_tgt_s;
  logic [31:0] jump_tgt_s;
  logic [31:0] npc_s;
  logic        exc_f_s;

  // Candidate targets; all additions wrap modulo 2^32.
  always_comb begin
    pc_plus4_s   = pc_f_r + 32'd4;
    imm_off_s    = {{14{instr_d_r[15]}}, instr_d_r[15:0], 2'b00};
    branch_tgt_s = pc_d_r + 32'd4 + imm_off_s;
    jump_tgt_s   = {pc_d_r[31:28], instr_d_r[25:0], 2'b00};
  end

  // Next-PC select; unlisted opcodes and a not-taken branch fall through sequentially.
  always_comb begin
    npc_s = pc_plus4_s;
    case (npc_op_D)
      NPC_SEQ: npc_s = pc_plus4_s;
      NPC_BRANCH: begin
        if (branch_signal_D) begin
          npc_s = branch_tgt_s;
        end else begin
          npc_s = pc_plus4_s;
        end
      end
      NPC_JUMP: npc_s = jump_tgt_s;
      NPC_JR:   npc_s = rs_fwd_D;
      default:  npc_s = pc_plus4_s;
    endcase
  end

  // Fetch address error: misaligned or outside the instruction window.
  always_comb begin
    exc_f_s = (pc_f_r[1:0] != 2'b00) || (pc_f_r < PC_LO) || (pc_f_r > PC_HI);
  end

  // PC and F/D register; reset beats stall, stall beats any redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_r    <= PC_RESET;
      instr_d_r <= NOP;
      pc_d_r    <= 32'h0000_0000;
      exc_d_r   <= 1'b0;
    end else if (!stall) begin
      pc_f_r    <= npc_s;
      instr_d_r <= exc_f_s ? NOP : instr_F;
      pc_d_r    <= pc_f_r;
      exc_d_r   <= exc_f_s;
    end else begin
      pc_f_r    <= pc_f_r;
      instr_d_r <= instr_d_r;
      pc_d_r    <= pc_d_r;
      exc_d_r   <= exc_d_r;
    end
  end

  assign pc_F    = pc_f_r;
  assign instr_D = instr_d_r;
  assign pc_D    = pc_d_r;
  assign exc_D   = exc_d_r;
  assign pc8_D   = pc_d_r + 32'd8;

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Directed bench for f_pc_ctrl: a small instruction-memory model feeds instr_F
// and each step is checked against hand-computed values with immediate assertions.
module tb_f_pc_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_signal_D;
  logic [2:0]  npc_op_D;
  logic [31:0] rs_fwd_D;
  logic [31:0] instr_F;
  logic [31:0] pc_F;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc8_D;
  logic        exc_D;

  int n_checks;
  int n_fail;

  f_pc_ctrl dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .branch_signal_D(branch_signal_D),
    .npc_op_D(npc_op_D),
    .rs_fwd_D(rs_fwd_D),
    .instr_F(instr_F),
    .pc_F(pc_F),
    .instr_D(instr_D),
    .pc_D(pc_D),
    .pc8_D(pc8_D),
    .exc_D(exc_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // beq $0,$0,-1 at 0x3010, jal index 0xC10 at 0x3020, tagged filler elsewhere.
  function automatic logic [31:0] imem(input logic [31:0] a);
    logic [31:0] w;
    case (a)
      32'h0000_3010: w = 32'h1000_FFFF;
      32'h0000_3020: w = 32'h0C00_0C10;
      default:       w = {16'hAB00, a[15:0]};
    endcase
    return w;
  endfunction

  assign instr_F = imem(pc_F);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic stl, input logic [2:0] op,
                       input logic br, input logic [31:0] rs);
    reset           = rst;
    stall           = stl;
    npc_op_D        = op;
    branch_signal_D = br;
    rs_fwd_D        = rs;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive(1'b1, 1'b0, 3'b000, 1'b0, 32'h0);

    // Reset for two cycles
    step();
    step();
    check("rst_pc_F", pc_F, 32'h0000_3000);
    check("rst_instr_D", instr_D, 32'h0);
    check("rst_pc_D", pc_D, 32'h0);
    check("rst_exc_D", {31'd0, exc_D}, 32'd0);
    check("rst_pc8_D", pc8_D, 32'h0000_0008);

    // Sequential fetch, pc_D lags by one
    drive(1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
    step();
    check("seq1_pc_F", pc_F, 32'h0000_3004);
    check("seq1_pc_D", pc_D, 32'h0000_3000);
    check("seq1_instr_D", instr_D, 32'hAB00_3000);
    step();
    check("seq2_pc_F", pc_F, 32'h0000_3008);
    check("seq2_pc_D", pc_D, 32'h0000_3004);
    step();
    step();
    step();
    check("beq_in_D_pc_D", pc_D, 32'h0000_3010);
    check("beq_in_D_instr", instr_D, 32'h1000_FFFF);
    check("beq_in_D_pc_F", pc_F, 32'h0000_3014);

    // Taken branch to self with delay slot latched
    drive(1'b0, 1'b0, 3'b001, 1'b1, 32'h0);
    step();
    check("beq_pc_F", pc_F, 32'h0000_3010);
    check("beq_slot_pc_D", pc_D, 32'h0000_3014);
    check("beq_slot_instr", instr_D, 32'hAB00_3014);

    // Bring beq back into D, then stall two cycles with branch pending
    drive(1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
    step();
    check("beq2_pc_D", pc_D, 32'h0000_3010);
    drive(1'b0, 1'b1, 3'b001, 1'b1, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_pc_F", pc_F, 32'h0000_3014);
      check("stall_pc_D", pc_D, 32'h0000_3010);
      check("stall_instr_D", instr_D, 32'h1000_FFFF);
    end
    drive(1'b0, 1'b0, 3'b001, 1'b1, 32'h0);
    step();
    check("unstall_pc_F", pc_F, 32'h0000_3010);
    check("unstall_pc_D", pc_D, 32'h0000_3014);

    // Branch op with condition false goes sequential
    drive(1'b0, 1'b0, 3'b001, 1'b0, 32'h0);
    step();
    check("bnt_pc_F", pc_F, 32'h0000_3014);

    // Walk to the jal
    drive(1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step();
    check("jal_pc_D", pc_D, 32'h0000_3020);
    check("jal_pc8_D", pc8_D, 32'h0000_3028);
    check("jal_pc_F_pre", pc_F, 32'h0000_3024);
    drive(1'b0, 1'b0, 3'b010, 1'b0, 32'h0);
    step();
    check("jal_pc_F", pc_F, 32'h0000_3040);
    check("jal_slot_pc_D", pc_D, 32'h0000_3024);

    // jr to a misaligned address
    drive(1'b0, 1'b0, 3'b011, 1'b0, 32'h0000_3002);
    step();
    check("jr_pc_F", pc_F, 32'h0000_3002);
    check("jr_exc_D_slot", {31'd0, exc_D}, 32'd0);
    drive(1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
    step();
    check("mis_exc_D", {31'd0, exc_D}, 32'd1);
    check("mis_instr_D", instr_D, 32'h0);
    check("mis_pc_D", pc_D, 32'h0000_3002);
    check("mis_pc_F", pc_F, 32'h0000_3006);

    // Window boundaries: 0x6FFC valid, 0x7000 and 0x2FFC out of range
    drive(1'b0, 1'b0, 3'b011, 1'b0, 32'h0000_6FFC);
    step();
    drive(1'b0, 1'b0, 3'b011, 1'b0, 32'h0000_7000);
    step();
    check("hi_ok_pc_D", pc_D, 32'h0000_6FFC);
    check("hi_ok_exc_D", {31'd0, exc_D}, 32'd0);
    check("hi_ok_instr_D", instr_D, 32'hAB00_6FFC);
    drive(1'b0, 1'b0, 3'b011, 1'b0, 32'h0000_2FFC);
    step();
    check("hi_bad_exc_D", {31'd0, exc_D}, 32'd1);
    check("hi_bad_instr_D", instr_D, 32'h0);
    drive(1'b0, 1'b0, 3'b011, 1'b0, 32'hFFFF_FFFC);
    step();
    check("lo_bad_pc_D", pc_D, 32'h0000_2FFC);
    check("lo_bad_exc_D", {31'd0, exc_D}, 32'd1);

    // Wrap of pc_F+4 at the top of the address space
    drive(1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
    step();
    check("wrap_pc_F", pc_F, 32'h0000_0000);
    check("wrap_pc_D", pc_D, 32'hFFFF_FFFC);
    check("wrap_pc8_D", pc8_D, 32'h0000_0004);

    // Unlisted opcode behaves sequentially
    drive(1'b0, 1'b0, 3'b111, 1'b1, 32'h0000_3100);
    step();
    check("op111_pc_F", pc_F, 32'h0000_0004);
    check("op111_exc_D", {31'd0, exc_D}, 32'd1);

    // Reset wins over stall and a pending jump
    drive(1'b1, 1'b1, 3'b010, 1'b0, 32'h0);
    step();
    check("rst_prio_pc_F", pc_F, 32'h0000_3000);
    check("rst_prio_instr_D", instr_D, 32'h0);
    check("rst_prio_exc_D", {31'd0, exc_D}, 32'd0);
    check("rst_prio_pc_D", pc_D, 32'h0);
    drive(1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
    step();
    check("post_rst_pc_F", pc_F, 32'h0000_3004);
    check("post_rst_pc_D", pc_D, 32'h0000_3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
